// File: rtl/direction_input.sv
// ---------------------------------------------------------------------------
// direction_input
//   Turns four raw push buttons into a one-hot direction command for the
//   movement block. The command is gated by a small game-state machine with
//   three states: INIT, RUN and HALT.
//
//   Each button goes through the same chain:
//     2-flop synchronizer -> counter-based debouncer -> rising-edge press event
//   When several buttons produce a press event in the same cycle, the winner
//   is chosen with priority Left > Right > Up > Down.
//   The latency from a clean raw edge to the output is
//   2 + DEBOUNCE_CYCLES + 1 clocks.
//
//   Optional feature (macro DIR_STICKY_EN):
//     defined   - the direction is held after the button is released
//     undefined - the direction clears once the selected button's debounced
//                 level falls
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive differing cycles needed to accept a change
//                     (minimum 2)
//
// Ports
//   clk                      : system clock, all state on posedge
//   reset                    : synchronous, active-high
//   btnL/btnU/btnR/btnD      : raw asynchronous buttons, high = pressed
//   start                    : INIT -> RUN
//   ack                      : HALT -> INIT
//   win, lose                : RUN -> HALT (direction cleared)
//   Left/Up/Right/Down       : registered one-hot direction command
//   playing                  : high while in RUN
// ---------------------------------------------------------------------------
module direction_input #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic btnL,
    input  logic btnU,
    input  logic btnR,
    input  logic btnD,
    input  logic start,
    input  logic ack,
    input  logic win,
    input  logic lose,
    output logic Left,
    output logic Up,
    output logic Right,
    output logic Down,
    output logic playing
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // The counter only ever reaches DEBOUNCE_CYCLES-1 before the stable level
    // is updated and the counter is cleared, so it cannot wrap.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // Bit order used throughout this module: [0]=Left [1]=Up [2]=Right [3]=Down
    logic [3:0]    raw_s;
    logic [3:0]    sync1_r;
    logic [3:0]    sync2_r;
    logic [3:0]    stable_r;
    logic [3:0]    stable_d_r;
    logic [CW-1:0] cnt_r [4];
    logic [3:0]    press_s;
    logic [3:0]    fall_s;
    logic [3:0]    dir_r;
    logic [3:0]    dir_next_s;
    state_t        state_r;
    state_t        state_next_s;
    logic          playing_r;

    assign raw_s = {btnD, btnR, btnU, btnL};

    // Edge events, computed from the debounced level and its one-cycle delay.
    assign press_s = stable_r & ~stable_d_r;
    assign fall_s  = ~stable_r & stable_d_r;

    // Priority select over simultaneous press events: Left > Right > Up > Down.
    function automatic logic [3:0] pick_press(input logic [3:0] p);
        logic [3:0] sel;
        if (p[0]) begin
            sel = 4'b0001;
        end else if (p[2]) begin
            sel = 4'b0100;
        end else if (p[1]) begin
            sel = 4'b0010;
        end else if (p[3]) begin
            sel = 4'b1000;
        end else begin
            sel = 4'b0000;
        end
        return sel;
    endfunction

    // Synchronizers and per-button debounce counters. These run in every
    // state, so a button that is already held when RUN is entered is
    // already debounced.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r    <= 4'b0000;
            sync2_r    <= 4'b0000;
            stable_r   <= 4'b0000;
            stable_d_r <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            sync1_r    <= raw_s;
            sync2_r    <= sync1_r;
            stable_d_r <= stable_r;
            for (int i = 0; i < 4; i++) begin
                if (sync2_r[i] != stable_r[i]) begin
                    if (cnt_r[i] == CNT_LAST) begin
                        stable_r[i] <= sync2_r[i];
                        cnt_r[i]    <= '0;
                    end else begin
                        cnt_r[i] <= cnt_r[i] + CNT_ONE;
                    end
                end else begin
                    cnt_r[i] <= '0;
                end
            end
        end
    end

    // Next-state logic and the direction register update.
    always_comb begin
        state_next_s = state_r;
        dir_next_s   = dir_r;
        case (state_r)
            INIT: begin
                dir_next_s = 4'b0000;
                if (start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = INIT;
                end
            end
            RUN: begin
                // Entering HALT takes precedence over a press event
                // arriving in the same cycle.
                if (win || lose) begin
                    state_next_s = HALT;
                    dir_next_s   = 4'b0000;
                end else if (|press_s) begin
                    dir_next_s = pick_press(press_s);
                end else begin
`ifdef DIR_STICKY_EN
                    dir_next_s = dir_r;
`else
                    // Only a release of the selected button clears the
                    // command. Other buttons still held stay silent until
                    // they produce a new press event.
                    if (|(dir_r & fall_s)) begin
                        dir_next_s = 4'b0000;
                    end else begin
                        dir_next_s = dir_r;
                    end
`endif
                end
            end
            HALT: begin
                dir_next_s = 4'b0000;
                if (ack) begin
                    state_next_s = INIT;
                end else begin
                    state_next_s = HALT;
                end
            end
            default: begin
                state_next_s = INIT;
                dir_next_s   = 4'b0000;
            end
        endcase
    end

    // State, direction and playing registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= INIT;
            dir_r     <= 4'b0000;
            playing_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            dir_r     <= dir_next_s;
            playing_r <= (state_next_s == RUN);
        end
    end

    assign Left    = dir_r[0];
    assign Up      = dir_r[1];
    assign Right   = dir_r[2];
    assign Down    = dir_r[3];
    assign playing = playing_r;

endmodule
